bist_ctrl: RTL and testbench

//  Sequencing controller for the AND-gate BIST datapath. It pulses init, then

---
 rtl/bist_ctrl_pkg.sv | 16 +
 rtl/bist_cycle_cnt.sv | 30 +++
 rtl/bist_ctrl.sv | 111 +++++++++++
 tb/tb_bist_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bist_ctrl_pkg.sv
// Shared definitions for the BIST controller: state encoding and the
// signature defaults that must agree with the ORA and pattern generator.
package bist_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_RUN    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int                   DEF_SIG_W      = 3;
  localparam logic [DEF_SIG_W-1:0] DEF_GOLDEN_SIG = 3'b101;

endpackage

// File: rtl/bist_cycle_cnt.sv
// Up-counter cleared by clr, advancing on inc, with a flag raised on the
// last count of a TERM-long window. It holds at the last count instead of wrapping.
module bist_cycle_cnt #(
  parameter int W    = 3,
  parameter int TERM = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam logic [W-1:0] LAST = W'(TERM - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/bist_ctrl.sv
// BIST sequencer: pulses init, holds en for N_PATTERNS cycles, waits a settle
// window, then captures the ORA signature and flags pass against GOLDEN_SIG.
module bist_ctrl
  import bist_ctrl_pkg::*;
#(
  parameter int               SIG_W      = DEF_SIG_W,
  parameter int               N_PATTERNS = 7,
  parameter int               CNT_W      = 3,
  parameter int               SETTLE_CYC = 1,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = DEF_GOLDEN_SIG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [SIG_W-1:0] sig,
  output logic             init,
  output logic             en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] sig_cap
);

  localparam int SCNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  function automatic logic sig_match(input logic [SIG_W-1:0] s);
    return (s == GOLDEN_SIG);
  endfunction

  state_t state;
  logic   p_tc;
  logic   s_tc;

  // Counters sit at zero outside their own state, so each window starts fresh.
  bist_cycle_cnt #(.W(CNT_W), .TERM(N_PATTERNS)) u_pcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != ST_RUN),
    .inc   (state == ST_RUN),
    .tc    (p_tc)
  );

  bist_cycle_cnt #(.W(SCNT_W), .TERM(SETTLE_CYC)) u_scnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != ST_SETTLE),
    .inc   (state == ST_SETTLE),
    .tc    (s_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      init    <= 1'b0;
      en      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      sig_cap <= '0;
    end else if (abort) begin
      state   <= ST_IDLE;
      init    <= 1'b0;
      en      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      sig_cap <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state   <= ST_INIT;
            init    <= 1'b1;
            busy    <= 1'b1;
            done    <= 1'b0;
            pass    <= 1'b0;
            sig_cap <= '0;
          end
        end
        ST_INIT: begin
          state <= ST_RUN;
          init  <= 1'b0;
          en    <= 1'b1;
        end
        ST_RUN: begin
          if (p_tc) begin
            state <= ST_SETTLE;
            en    <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (s_tc) begin
            state   <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= sig_match(sig);
            sig_cap <= sig;
          end
        end
        default: begin
          state <= ST_IDLE;
          init  <= 1'b0;
          en    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_ctrl.sv
// Directed-plus-random bench for bist_ctrl: a default instance and a
// short-window instance (N_PATTERNS=1, SETTLE_CYC=2) share clock and reset.
module tb_bist_ctrl;

  localparam logic [2:0] GOLDEN = 3'b101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start, abort;
  logic [2:0] sig;
  logic       init, en, busy, done, pass;
  logic [2:0] sig_cap;

  logic       start6, abort6;
  logic [2:0] sig6;
  logic       init6, en6, busy6, done6, pass6;
  logic [2:0] sig_cap6;

  bist_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sig(sig),
    .init(init), .en(en), .busy(busy), .done(done), .pass(pass), .sig_cap(sig_cap)
  );

  bist_ctrl #(.N_PATTERNS(1), .SETTLE_CYC(2)) dut6 (
    .clk(clk), .rst_n(rst_n), .start(start6), .abort(abort6), .sig(sig6),
    .init(init6), .en(en6), .busy(busy6), .done(done6), .pass(pass6), .sig_cap(sig_cap6)
  );

  logic       sel = 1'b0;
  logic       o_init, o_en, o_busy, o_done, o_pass;
  logic [2:0] o_sig_cap;
  assign o_init    = sel ? init6    : init;
  assign o_en      = sel ? en6      : en;
  assign o_busy    = sel ? busy6    : busy;
  assign o_done    = sel ? done6    : done;
  assign o_pass    = sel ? pass6    : pass;
  assign o_sig_cap = sel ? sig_cap6 : sig_cap;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic ab, input logic [2:0] sg);
    if (sel) begin
      start6 = st; abort6 = ab; sig6 = sg;
    end else begin
      start = st; abort = ab; sig = sg;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_init"}, o_init, 0);
    chk({tag, "_en"}, o_en, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_pass"}, o_pass, 0);
    chk({tag, "_sigcap"}, o_sig_cap, 0);
  endtask

  // One complete run: done is due on edge 2+n+s counted from the start-sampling edge.
  task automatic run(input int n, input int s, input logic [2:0] cmp_sig, input int glitch);
    int lat;
    int en_cnt;
    int init_cnt;
    lat = 2 + n + s;
    drive(1'b1, 1'b0, 3'($urandom));
    tick;
    init_cnt = int'(o_init);
    en_cnt   = int'(o_en);
    chk("start_busy", o_busy, 1);
    chk("start_done", o_done, 0);
    for (int k = 1; k < lat; k++) begin
      drive(k == glitch, 1'b0, (k == lat - 1) ? cmp_sig : 3'($urandom));
      tick;
      init_cnt += int'(o_init);
      en_cnt   += int'(o_en);
      if (k < lat - 1) begin
        chk("early_done", o_done, 0);
        chk("early_pass", o_pass, 0);
      end
    end
    drive(1'b0, 1'b0, 3'($urandom));
    chk("run_done", o_done, 1);
    chk("run_busy", o_busy, 0);
    chk("run_en_cycles", en_cnt, n);
    chk("run_init_cycles", init_cnt, 1);
    chk("run_sigcap", o_sig_cap, cmp_sig);
    chk("run_pass", o_pass, cmp_sig == GOLDEN);
  endtask

  task automatic hold(input int cycles, input logic [2:0] cap);
    for (int h = 0; h < cycles; h++) begin
      drive(1'b0, 1'b0, 3'($urandom));
      tick;
      chk("hold_done", o_done, 1);
      chk("hold_sigcap", o_sig_cap, cap);
      chk("hold_pass", o_pass, cap == GOLDEN);
    end
  endtask

  task automatic clear_to_idle;
    drive(1'b0, 1'b1, 3'd0);
    tick;
    drive(1'b0, 1'b0, 3'd0);
  endtask

  initial begin
    logic [2:0] rs;
    start = 0; abort = 0; sig = 0;
    start6 = 0; abort6 = 0; sig6 = 0;

    // Reset state on both instances
    tick; tick;
    sel = 0; chk_idle("rst");
    sel = 1; chk_idle("rst6");
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    sel = 0;

    // Golden signature, then a failing one held across idle cycles
    run(7, 1, 3'b101, 0);
    hold(3, 3'b101);
    run(7, 1, 3'b100, 0);
    hold(4, 3'b100);

    // abort wins over start in DONE
    drive(1'b1, 1'b1, 3'd0);
    tick;
    drive(1'b0, 1'b0, 3'd0);
    chk_idle("abort_vs_start");

    // abort during the 3rd RUN cycle, then a full rerun
    drive(1'b1, 1'b0, 3'd0);
    tick;
    drive(1'b0, 1'b0, 3'd0);
    tick; tick; tick;
    chk("run3_en", o_en, 1);
    drive(1'b0, 1'b1, 3'd0);
    tick;
    drive(1'b0, 1'b0, 3'd0);
    chk_idle("abort_run");
    tick;
    chk("abort_stays_idle", o_busy, 0);
    run(7, 1, 3'b101, 0);

    // Asynchronous reset in SETTLE
    clear_to_idle();
    drive(1'b1, 1'b0, 3'd0);
    tick;
    drive(1'b0, 1'b0, 3'd0);
    for (int k = 0; k < 8; k++) tick;
    chk("settle_en", o_en, 0);
    chk("settle_busy", o_busy, 1);
    #2 rst_n = 1'b0;
    #1 chk_idle("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick; tick;
    chk("post_rst_idle", o_busy, 0);
    chk("post_rst_done", o_done, 0);

    // start pulsed during RUN is ignored; start held in DONE retriggers
    run(7, 1, 3'b011, 4);
    drive(1'b1, 1'b0, 3'd0);
    tick;
    chk("retrig_done", o_done, 0);
    chk("retrig_pass", o_pass, 0);
    chk("retrig_init", o_init, 1);
    chk("retrig_busy", o_busy, 1);
    chk("retrig_sigcap", o_sig_cap, 0);
    clear_to_idle();

    // Randomized runs on the default instance
    for (int r = 0; r < 4; r++) begin
      rs = ($urandom_range(0, 1) == 1) ? GOLDEN : 3'($urandom);
      run(7, 1, rs, 0);
      hold(int'($urandom_range(0, 2)), rs);
    end
    clear_to_idle();

    // Short-window instance
    sel = 1;
    tick;
    run(1, 2, 3'b101, 0);
    hold(2, 3'b101);
    for (int r = 0; r < 3; r++) begin
      rs = 3'($urandom);
      run(1, 2, rs, 0);
    end
    clear_to_idle();
    tick;
    chk_idle("dut6_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
